// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch resolve, EX/MEM register.
// Define EX_PERF_CNT_EN to add the ExecCntE / TakenCntE performance counters.
module ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              EnM,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              MemWriteE,
    input  logic              JumpE,
    input  logic              BranchE,
    input  logic [2:0]        ALUControlE,
    input  logic              ALUSrcE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] PCE,
    input  logic [4:0]        RdE,
    input  logic [DATA_W-1:0] ImmExtE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              RegWriteM,
    output logic [1:0]        ResultSrcM,
    output logic              MemWriteM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [4:0]        RdM,
    output logic [DATA_W-1:0] PCPlus4M
`ifdef EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  ExecCntE,
    output logic [CNT_W-1:0]  TakenCntE
`endif
);

    logic [DATA_W-1:0] srcAE;
    logic [DATA_W-1:0] writeDataE;
    logic [DATA_W-1:0] srcBE;
    logic [DATA_W-1:0] aluResultE;
    logic              zeroE;
    logic              sltE;

    // Forwarding select 2'b11 is unused by the hazard unit and falls back to the register file.
    always_comb begin
        srcAE = RD1E;
        case (ForwardAE)
            2'b01:   srcAE = ResultW;
            2'b10:   srcAE = ALUResultM;
            default: srcAE = RD1E;
        endcase
    end

    always_comb begin
        writeDataE = RD2E;
        case (ForwardBE)
            2'b01:   writeDataE = ResultW;
            2'b10:   writeDataE = ALUResultM;
            default: writeDataE = RD2E;
        endcase
    end

    assign srcBE = ALUSrcE ? ImmExtE : writeDataE;
    assign sltE  = ($signed(srcAE) < $signed(srcBE));

    always_comb begin
        aluResultE = '0;
        unique case (ALUControlE)
            3'b000: aluResultE = srcAE + srcBE;
            3'b001: aluResultE = srcAE - srcBE;
            3'b010: aluResultE = srcAE & srcBE;
            3'b011: aluResultE = srcAE | srcBE;
            3'b100: aluResultE = srcAE ^ srcBE;
            3'b101: aluResultE = {{(DATA_W-1){1'b0}}, sltE};
            3'b110: aluResultE = srcAE << srcBE[4:0];
            3'b111: aluResultE = srcAE >> srcBE[4:0];
            default: aluResultE = '0;
        endcase
    end

    assign zeroE     = (aluResultE == '0);
    assign PCSrcE    = JumpE | (BranchE & zeroE);
    assign PCTargetE = PCE + ImmExtE;

    // Reset takes priority over the memory-side stall so a flush always lands as a bubble.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            RegWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            MemWriteM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RdM        <= '0;
            PCPlus4M   <= '0;
        end else if (EnM) begin
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            MemWriteM  <= MemWriteE;
            ALUResultM <= aluResultE;
            WriteDataM <= writeDataE;
            RdM        <= RdE;
            PCPlus4M   <= PCPlus4E;
        end
    end

`ifdef EX_PERF_CNT_EN
    logic execValidE;
    assign execValidE = RegWriteE | MemWriteE | BranchE | JumpE;

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            ExecCntE  <= '0;
            TakenCntE <= '0;
        end else if (EnM) begin
            if (execValidE) ExecCntE  <= ExecCntE + CNT_W'(1);
            if (PCSrcE)     TakenCntE <= TakenCntE + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; counter checks compile in only with EX_PERF_CNT_EN.
module tb_ex_stage;

    logic        CLK;
    logic        CLR;
    logic        EnM;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] PCE;
    logic [4:0]  RdE;
    logic [31:0] ImmExtE;
    logic [31:0] PCPlus4E;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
`ifdef EX_PERF_CNT_EN
    logic [31:0] ExecCntE;
    logic [31:0] TakenCntE;
`endif

    int numChecks = 0;
    int numErrors = 0;

    ex_stage #(
        .DATA_W(32),
        .CNT_W (32)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .EnM        (EnM),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .JumpE      (JumpE),
        .BranchE    (BranchE),
        .ALUControlE(ALUControlE),
        .ALUSrcE    (ALUSrcE),
        .RD1E       (RD1E),
        .RD2E       (RD2E),
        .PCE        (PCE),
        .RdE        (RdE),
        .ImmExtE    (ImmExtE),
        .PCPlus4E   (PCPlus4E),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ResultW    (ResultW),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M)
`ifdef EX_PERF_CNT_EN
        ,
        .ExecCntE   (ExecCntE),
        .TakenCntE  (TakenCntE)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setAlu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        RD1E        = a;
        RD2E        = b;
        ALUControlE = op;
        ALUSrcE     = 1'b0;
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
    endtask

    task automatic clearCtrl();
        RegWriteE = 1'b0;
        MemWriteE = 1'b0;
        JumpE     = 1'b0;
        BranchE   = 1'b0;
    endtask

    initial begin
        CLR = 1'b0; EnM = 1'b1;
        RegWriteE = 1'b1; ResultSrcE = 2'b10; MemWriteE = 1'b1;
        JumpE = 1'b0; BranchE = 1'b0;
        setAlu(32'd5, 32'd7, 3'b000);
        PCE = 32'h100; RdE = 5'd3; ImmExtE = 32'd0; PCPlus4E = 32'h104; ResultW = 32'd0;

        // Reset clears every M output.
        tick();
        check("rst_regwrite", {31'd0, RegWriteM}, 32'd0);
        check("rst_memwrite", {31'd0, MemWriteM}, 32'd0);
        check("rst_resultsrc", {30'd0, ResultSrcM}, 32'd0);
        check("rst_alu", ALUResultM, 32'd0);
        check("rst_wdata", WriteDataM, 32'd0);
        check("rst_rd", {27'd0, RdM}, 32'd0);
        check("rst_pc4", PCPlus4M, 32'd0);

        // ALU operations.
        CLR = 1'b1; MemWriteE = 1'b0; ResultSrcE = 2'b01;
        tick();
        check("add", ALUResultM, 32'd12);
        check("add_rd", {27'd0, RdM}, 32'd3);
        check("add_regwrite", {31'd0, RegWriteM}, 32'd1);
        check("add_resultsrc", {30'd0, ResultSrcM}, 32'd1);
        check("add_pc4", PCPlus4M, 32'h104);
        check("add_wdata", WriteDataM, 32'd7);
        ALUControlE = 3'b001; tick();
        check("sub", ALUResultM, 32'hFFFF_FFFE);
        setAlu(32'hFFFF_FFFF, 32'd1, 3'b101); tick();
        check("slt_neg", ALUResultM, 32'd1);
        setAlu(32'd1, 32'hFFFF_FFFF, 3'b101); tick();
        check("slt_false", ALUResultM, 32'd0);
        setAlu(32'd1, 32'd35, 3'b110); tick();
        check("sll", ALUResultM, 32'd8);
        setAlu(32'h8000_0000, 32'd4, 3'b111); tick();
        check("srl", ALUResultM, 32'h0800_0000);
        setAlu(32'h0000_F0F0, 32'h0000_FF00, 3'b010); tick();
        check("and", ALUResultM, 32'h0000_F000);
        ALUControlE = 3'b011; tick();
        check("or", ALUResultM, 32'h0000_FFF0);
        ALUControlE = 3'b100; tick();
        check("xor", ALUResultM, 32'h0000_0FF0);
        setAlu(32'hFFFF_FFFF, 32'd2, 3'b000); tick();
        check("add_wrap", ALUResultM, 32'd1);

        // Forwarding from ALUResultM, ResultW, and the 2'b11 fallback.
        setAlu(32'd3, 32'd4, 3'b000); tick();
        check("fwd_base", ALUResultM, 32'd7);
        setAlu(32'd0, 32'd0, 3'b000);
        ForwardAE = 2'b10; ImmExtE = 32'd1; ALUSrcE = 1'b1; tick();
        check("fwd_a_mem", ALUResultM, 32'd8);
        setAlu(32'h20, 32'd0, 3'b000);
        ForwardBE = 2'b01; ResultW = 32'hAA; MemWriteE = 1'b1; ALUSrcE = 1'b1; ImmExtE = 32'd4;
        tick();
        check("fwd_b_wb", WriteDataM, 32'hAA);
        check("fwd_b_store", {31'd0, MemWriteM}, 32'd1);
        check("fwd_b_alu", ALUResultM, 32'h24);
        setAlu(32'd10, 32'd6, 3'b000); ForwardAE = 2'b11; ForwardBE = 2'b11; MemWriteE = 1'b0;
        tick();
        check("fwd_11", ALUResultM, 32'd16);
        check("fwd_11_wd", WriteDataM, 32'd6);

        // Branch / jump resolution is combinational.
        setAlu(32'd9, 32'd9, 3'b001);
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8; BranchE = 1'b1; #1;
        check("beq_taken", {31'd0, PCSrcE}, 32'd1);
        check("pc_target", PCTargetE, 32'h0000_00F8);
        RD2E = 32'd8; #1;
        check("beq_not", {31'd0, PCSrcE}, 32'd0);
        JumpE = 1'b1; #1;
        check("jal", {31'd0, PCSrcE}, 32'd1);
        JumpE = 1'b0; BranchE = 1'b0; RD2E = 32'd9; #1;
        check("no_branch", {31'd0, PCSrcE}, 32'd0);

        // Stall holds all M outputs while E inputs change.
        setAlu(32'd1, 32'd1, 3'b000); RegWriteE = 1'b1; RdE = 5'd5; PCPlus4E = 32'h200;
        tick();
        check("pre_stall", ALUResultM, 32'd2);
        EnM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            RD1E = 32'd100 + 32'(i); RdE = 5'(10 + i); RegWriteE = 1'b0; PCPlus4E = 32'h300;
            MemWriteE = 1'b1;
            tick();
            check("stall_alu", ALUResultM, 32'd2);
            check("stall_rd", {27'd0, RdM}, 32'd5);
            check("stall_rw", {31'd0, RegWriteM}, 32'd1);
            check("stall_mw", {31'd0, MemWriteM}, 32'd0);
            check("stall_pc4", PCPlus4M, 32'h200);
        end
        EnM = 1'b1; MemWriteE = 1'b0;
        setAlu(32'd10, 32'd20, 3'b000); RegWriteE = 1'b1; RdE = 5'd9;
        tick();
        check("unstall_alu", ALUResultM, 32'd30);
        check("unstall_rd", {27'd0, RdM}, 32'd9);

        // Synchronous reset only acts on the edge, and wins over EnM=0.
        CLR = 1'b0; #2;
        check("clr_noedge_rw", {31'd0, RegWriteM}, 32'd1);
        check("clr_noedge_alu", ALUResultM, 32'd30);
        JumpE = 1'b1; #1;
        check("clr_pcsrc", {31'd0, PCSrcE}, 32'd1);
        JumpE = 1'b0;
        tick();
        check("clr_rw", {31'd0, RegWriteM}, 32'd0);
        check("clr_alu", ALUResultM, 32'd0);
        CLR = 1'b1; tick();
        check("reload", ALUResultM, 32'd30);
        CLR = 1'b0; EnM = 1'b0; tick();
        check("clr_over_stall", ALUResultM, 32'd0);
        EnM = 1'b1;

`ifdef EX_PERF_CNT_EN
        clearCtrl(); tick();
        check("cnt_clr_exec", ExecCntE, 32'd0);
        check("cnt_clr_taken", TakenCntE, 32'd0);
        CLR = 1'b1;
        setAlu(32'd1, 32'd2, 3'b000);
        RegWriteE = 1'b1; tick(); clearCtrl();
        JumpE = 1'b1; tick(); clearCtrl();
        setAlu(32'd4, 32'd4, 3'b001); BranchE = 1'b1; tick(); clearCtrl();
        setAlu(32'd1, 32'd2, 3'b000); MemWriteE = 1'b1; tick(); clearCtrl();
        EnM = 1'b0; JumpE = 1'b1; tick(); clearCtrl(); EnM = 1'b1;
        tick();
        check("cnt_exec", ExecCntE, 32'd4);
        check("cnt_taken", TakenCntE, 32'd2);
        CLR = 1'b0; tick();
        check("cnt_exec_clr", ExecCntE, 32'd0);
        check("cnt_taken_clr", TakenCntE, 32'd0);
        CLR = 1'b1;
`else
        clearCtrl();
`endif

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
